// File: rtl/ili9341_spi_monitor.sv
`default_nettype none
// ============================================================================
// Module   : ili9341_spi_monitor
// Brief    : Display-side receiver for the ILI9341 4-wire write-only SPI link.
//            Oversamples the bus, deserialises command/data bytes, tracks the
//            window/RAMWR/power commands and emits RGB565 pixels with (x,y).
// Revision : 1.0 - initial release
// ============================================================================
module ili9341_spi_monitor #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [15:0] DEF_EC      = 16'd239,
   parameter logic [15:0] DEF_EP      = 16'd319
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_spi_sclk,
   input  logic        i_spi_cs_n,
   input  logic        i_spi_dc,
   input  logic        i_spi_din,
   output logic        o_byte_valid,
   output logic [7:0]  o_byte_data,
   output logic        o_byte_is_cmd,
   output logic        o_pix_valid,
   output logic [15:0] o_pix_data,
   output logic [15:0] o_pix_x,
   output logic [15:0] o_pix_y,
   output logic        o_frame_done,
   output logic        o_sleep_out,
   output logic        o_disp_on,
   output logic        o_err_abort
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CASET  = 3'd1,
      S_PASET  = 3'd2,
      S_RAMWR  = 3'd3,
      S_IGNORE = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Front end: synchronisers, sclk edge detect, byte assembly
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_dc_sync, r_din_sync;
   logic                   r_sclk_q;
   logic [6:0]             r_shift;
   logic [2:0]             r_cnt;
   logic                   r_bv, r_cmd, r_err;
   logic [7:0]             r_byte;

   logic w_sclk, w_cs_n, w_dc, w_din, w_rise;
   assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
   assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
   assign w_dc   = r_dc_sync[SYNC_STAGES-1];
   assign w_din  = r_din_sync[SYNC_STAGES-1];
   assign w_rise = w_sclk & ~r_sclk_q;

   // Bring the asynchronous SPI nets into the clk domain; cs_n idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '1;
         r_dc_sync   <= '0;
         r_din_sync  <= '0;
         r_sclk_q    <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   i_spi_cs_n};
         r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0],   i_spi_dc};
         r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0],  i_spi_din};
         r_sclk_q    <= w_sclk;
      end
   end

   // Shift MSB-first on each sclk rise; the 8th bit latches the byte and dc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_bv    <= 1'b0;
         r_cmd   <= 1'b0;
         r_err   <= 1'b0;
         r_byte  <= '0;
      end else if (w_cs_n) begin
         // Deselect mid-byte discards the partial byte and flags it once.
         r_cnt <= '0;
         r_bv  <= 1'b0;
         r_err <= (r_cnt != 3'd0);
      end else begin
         r_err <= 1'b0;
         r_bv  <= 1'b0;
         if (w_rise) begin
            r_shift <= {r_shift[5:0], w_din};
            if (r_cnt == 3'd7) begin
               r_byte <= {r_shift, w_din};
               r_cmd  <= ~w_dc;
               r_bv   <= 1'b1;
               r_cnt  <= '0;
            end else begin
               r_cnt <= r_cnt + 3'd1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Command decoder, window tracking and pixel walker
   // ------------------------------------------------------------------------
   state_t      r_state, w_state_nxt;
   logic [1:0]  r_idx, w_idx_nxt;
   logic [7:0]  r_p0, r_p1, r_p2, w_p0_nxt, w_p1_nxt, w_p2_nxt;
   logic [15:0] r_sc, r_ec, r_sp, r_ep, w_sc_nxt, w_ec_nxt, w_sp_nxt, w_ep_nxt;
   logic [15:0] r_x, r_y, w_x_nxt, w_y_nxt;
   logic        r_phase, w_phase_nxt;
   logic [7:0]  r_hi, w_hi_nxt;
   logic        r_sleep, r_disp, w_sleep_nxt, w_disp_nxt;
   logic        w_pix, w_x_end, w_y_end;

   // Decoder state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_p0    <= '0;
         r_p1    <= '0;
         r_p2    <= '0;
         r_sc    <= '0;
         r_ec    <= DEF_EC;
         r_sp    <= '0;
         r_ep    <= DEF_EP;
         r_x     <= '0;
         r_y     <= '0;
         r_phase <= 1'b0;
         r_hi    <= '0;
         r_sleep <= 1'b0;
         r_disp  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_p0    <= w_p0_nxt;
         r_p1    <= w_p1_nxt;
         r_p2    <= w_p2_nxt;
         r_sc    <= w_sc_nxt;
         r_ec    <= w_ec_nxt;
         r_sp    <= w_sp_nxt;
         r_ep    <= w_ep_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_phase <= w_phase_nxt;
         r_hi    <= w_hi_nxt;
         r_sleep <= w_sleep_nxt;
         r_disp  <= w_disp_nxt;
      end
   end

   // Low pixel byte in RAMWR completes a pixel in the same cycle as byte_valid.
   assign w_x_end = (r_x >= r_ec);
   assign w_y_end = (r_y >= r_ep);
   assign w_pix   = r_bv & ~r_cmd & (r_state == S_RAMWR) & r_phase;

   // Next-state logic: commands always restart decode, data follows the state.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_p0_nxt    = r_p0;
      w_p1_nxt    = r_p1;
      w_p2_nxt    = r_p2;
      w_sc_nxt    = r_sc;
      w_ec_nxt    = r_ec;
      w_sp_nxt    = r_sp;
      w_ep_nxt    = r_ep;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_phase_nxt = r_phase;
      w_hi_nxt    = r_hi;
      w_sleep_nxt = r_sleep;
      w_disp_nxt  = r_disp;
      if (r_bv && r_cmd) begin
         w_idx_nxt   = '0;
         w_phase_nxt = 1'b0;
         w_state_nxt = S_IDLE;
         case (r_byte)
            8'h2A: w_state_nxt = S_CASET;
            8'h2B: w_state_nxt = S_PASET;
            8'h2C: begin
               w_state_nxt = S_RAMWR;
               w_x_nxt     = r_sc;
               w_y_nxt     = r_sp;
            end
            8'h11: w_sleep_nxt = 1'b1;
            8'h10: w_sleep_nxt = 1'b0;
            8'h29: w_disp_nxt  = 1'b1;
            8'h28: w_disp_nxt  = 1'b0;
            8'h01: begin
               w_sc_nxt    = '0;
               w_ec_nxt    = DEF_EC;
               w_sp_nxt    = '0;
               w_ep_nxt    = DEF_EP;
               w_sleep_nxt = 1'b0;
               w_disp_nxt  = 1'b0;
            end
            default: w_state_nxt = S_IGNORE;
         endcase
      end else if (r_bv) begin
         case (r_state)
            S_CASET, S_PASET: begin
               // Window registers change only once all four parameters are in.
               if (r_idx == 2'd3) begin
                  if (r_state == S_CASET) begin
                     w_sc_nxt = {r_p0, r_p1};
                     w_ec_nxt = {r_p2, r_byte};
                  end else begin
                     w_sp_nxt = {r_p0, r_p1};
                     w_ep_nxt = {r_p2, r_byte};
                  end
                  w_state_nxt = S_IDLE;
                  w_idx_nxt   = '0;
               end else begin
                  case (r_idx)
                     2'd0:    w_p0_nxt = r_byte;
                     2'd1:    w_p1_nxt = r_byte;
                     default: w_p2_nxt = r_byte;
                  endcase
                  w_idx_nxt = r_idx + 2'd1;
               end
            end
            S_RAMWR: begin
               if (!r_phase) begin
                  w_hi_nxt    = r_byte;
                  w_phase_nxt = 1'b1;
               end else begin
                  w_phase_nxt = 1'b0;
                  if (w_x_end) begin
                     w_x_nxt = r_sc;
                     w_y_nxt = w_y_end ? r_sp : r_y + 16'd1;
                  end else begin
                     w_x_nxt = r_x + 16'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_byte_valid  = r_bv;
   assign o_byte_data   = r_byte;
   assign o_byte_is_cmd = r_cmd;
   assign o_err_abort   = r_err;
   assign o_pix_valid   = w_pix;
   assign o_pix_data    = {r_hi, r_byte};
   assign o_pix_x       = r_x;
   assign o_pix_y       = r_y;
   assign o_frame_done  = w_pix & w_x_end & w_y_end;
   assign o_sleep_out   = r_sleep;
   assign o_disp_on     = r_disp;

endmodule
`default_nettype wire

// File: tb/tb_ili9341_spi_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ili9341_spi_monitor
// Brief    : Directed self-checking bench for ili9341_spi_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ili9341_spi_monitor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b0, cs_n = 1'b1, dc = 1'b0, din = 1'b0;
   logic        byte_valid, byte_is_cmd, pix_valid, frame_done;
   logic        sleep_out, disp_on, err_abort;
   logic [7:0]  byte_data;
   logic [15:0] pix_data, pix_x, pix_y;

   int checks = 0;
   int failures = 0;

   ili9341_spi_monitor #(.SYNC_STAGES(2), .DEF_EC(16'd239), .DEF_EP(16'd319)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_spi_sclk(sclk), .i_spi_cs_n(cs_n), .i_spi_dc(dc), .i_spi_din(din),
      .o_byte_valid(byte_valid), .o_byte_data(byte_data), .o_byte_is_cmd(byte_is_cmd),
      .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_pix_x(pix_x), .o_pix_y(pix_y),
      .o_frame_done(frame_done), .o_sleep_out(sleep_out), .o_disp_on(disp_on),
      .o_err_abort(err_abort)
   );

   always #5 clk = ~clk;

   // Event capture on the falling edge, away from the active edge.
   logic [7:0]  bq_data[$];
   logic        bq_cmd[$];
   logic        bq_disp[$];
   logic [15:0] pq_data[$], pq_x[$], pq_y[$];
   logic        pq_fd[$];
   int          err_cnt = 0;
   int          stray_fd = 0;

   always @(negedge clk) begin
      if (byte_valid) begin
         bq_data.push_back(byte_data);
         bq_cmd.push_back(byte_is_cmd);
         bq_disp.push_back(disp_on);
      end
      if (pix_valid) begin
         pq_data.push_back(pix_data);
         pq_x.push_back(pix_x);
         pq_y.push_back(pix_y);
         pq_fd.push_back(frame_done);
      end
      if (frame_done && !pix_valid) stray_fd++;
      if (err_abort) err_cnt++;
   end

   task automatic clear_q();
      bq_data.delete(); bq_cmd.delete(); bq_disp.delete();
      pq_data.delete(); pq_x.delete(); pq_y.delete(); pq_fd.delete();
      err_cnt = 0;
   endtask

   task automatic send_bits(input logic [7:0] b, input logic is_data, input int n);
      if (cs_n) begin
         cs_n = 1'b0;
         #20;
      end
      for (int i = 7; i > 7 - n; i--) begin
         din = b[i];
         dc  = is_data;
         #30 sclk = 1'b1;
         #30 sclk = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic is_data);
      send_bits(b, is_data, 8);
   endtask

   task automatic end_xfer();
      #40 cs_n = 1'b1;
      #100;
   endtask

   task automatic send_seq(input logic [7:0] cmd, input logic [7:0] d[$]);
      send_byte(cmd, 1'b0);
      foreach (d[i]) send_byte(d[i], 1'b1);
   endtask

   task automatic chk_pix(input int k, input logic [15:0] d, input logic [15:0] x,
                          input logic [15:0] y, input logic fd);
      checks++;
      if (pq_data.size() <= k) begin
         failures++;
         $display("FAIL pix%0d missing: got %0d pixels", k, pq_data.size());
      end else if (pq_data[k] !== d || pq_x[k] !== x || pq_y[k] !== y || pq_fd[k] !== fd) begin
         failures++;
         $display("FAIL pix%0d: got %h@(%0d,%0d) fd=%b, want %h@(%0d,%0d) fd=%b",
                  k, pq_data[k], pq_x[k], pq_y[k], pq_fd[k], d, x, y, fd);
      end
   endtask

   task automatic test_reset();
      logic [7:0] e[$];
      #40 rst_n = 1'b1;
      #50;
      checks++;
      if ({byte_valid, byte_data, byte_is_cmd, pix_valid, pix_data, pix_x, pix_y,
           frame_done, sleep_out, disp_on, err_abort} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: some output nonzero after reset");
      end
      // Set flags, then reset mid-byte and check everything returns to zero.
      send_byte(8'h11, 1'b0);
      send_byte(8'h29, 1'b0);
      send_bits(8'hFF, 1'b1, 3);
      #20 rst_n = 1'b0;
      #5;
      checks++;
      if ({byte_valid, byte_data, byte_is_cmd, pix_valid, pix_data, pix_x, pix_y,
           frame_done, sleep_out, disp_on, err_abort} !== '0) begin
         failures++;
         $display("FAIL reset_async: sleep=%b disp=%b byte=%h, want all 0",
                  sleep_out, disp_on, byte_data);
      end
      #30 rst_n = 1'b1;
      #50;
      clear_q();
      send_seq(8'h11, e);
      end_xfer();
      checks++;
      if (bq_data.size() != 1 || bq_data[0] !== 8'h11 || bq_cmd[0] !== 1'b1) begin
         failures++;
         $display("FAIL reset_next_byte: got %0d bytes first=%h, want 1 byte 11 cmd",
                  bq_data.size(), (bq_data.size() > 0) ? bq_data[0] : 8'hxx);
      end
      checks++;
      if (sleep_out !== 1'b1 || disp_on !== 1'b0) begin
         failures++;
         $display("FAIL reset_slpout: sleep=%b disp=%b, want 1 0", sleep_out, disp_on);
      end
   endtask

   task automatic test_dispon();
      logic [7:0] e[$];
      clear_q();
      send_seq(8'h29, e);
      end_xfer();
      checks++;
      if (bq_data.size() != 1 || bq_data[0] !== 8'h29 || bq_cmd[0] !== 1'b1 || bq_disp[0] !== 1'b0) begin
         failures++;
         $display("FAIL dispon_byte: n=%0d data=%h cmd=%b disp_at_valid=%b, want 1 29 1 0",
                  bq_data.size(), bq_data.size() ? bq_data[0] : 8'hxx,
                  bq_cmd.size() ? bq_cmd[0] : 1'bx, bq_disp.size() ? bq_disp[0] : 1'bx);
      end
      checks++;
      if (disp_on !== 1'b1) begin
         failures++;
         $display("FAIL dispon_flag: got %b want 1", disp_on);
      end
   endtask

   task automatic test_window_frame();
      clear_q();
      send_seq(8'h2A, '{8'h00, 8'h0A, 8'h00, 8'h0B});
      send_seq(8'h2B, '{8'h00, 8'h14, 8'h00, 8'h15});
      send_seq(8'h2C, '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF});
      end_xfer();
      checks++;
      if (bq_data.size() != 19) begin
         failures++;
         $display("FAIL frame_bytes: got %0d want 19", bq_data.size());
      end
      checks++;
      if (pq_data.size() != 4) begin
         failures++;
         $display("FAIL frame_npix: got %0d want 4", pq_data.size());
      end
      chk_pix(0, 16'hF800, 16'd10, 16'd20, 1'b0);
      chk_pix(1, 16'h07E0, 16'd11, 16'd20, 1'b0);
      chk_pix(2, 16'h001F, 16'd10, 16'd21, 1'b0);
      chk_pix(3, 16'hFFFF, 16'd11, 16'd21, 1'b1);
   endtask

   task automatic test_abort();
      logic [7:0] e[$];
      clear_q();
      send_bits(8'hA5, 1'b1, 5);
      end_xfer();
      checks++;
      if (err_cnt != 1 || bq_data.size() != 0) begin
         failures++;
         $display("FAIL abort: err_pulses=%0d bytes=%0d, want 1 0", err_cnt, bq_data.size());
      end
      clear_q();
      send_seq(8'h28, e);
      end_xfer();
      checks++;
      if (bq_data.size() != 1 || bq_data[0] !== 8'h28 || bq_cmd[0] !== 1'b1 || disp_on !== 1'b0 || err_cnt != 0) begin
         failures++;
         $display("FAIL abort_next: n=%0d data=%h disp=%b err=%0d, want 1 28 0 0",
                  bq_data.size(), bq_data.size() ? bq_data[0] : 8'hxx, disp_on, err_cnt);
      end
   endtask

   task automatic test_partial_caset();
      logic [7:0] e[$];
      clear_q();
      send_seq(8'h11, e);
      send_seq(8'h29, e);
      send_seq(8'h01, e);
      end_xfer();
      checks++;
      if (sleep_out !== 1'b0 || disp_on !== 1'b0) begin
         failures++;
         $display("FAIL swreset_flags: sleep=%b disp=%b, want 0 0", sleep_out, disp_on);
      end
      clear_q();
      send_seq(8'h2A, '{8'h00, 8'h05, 8'h00});
      send_seq(8'h2C, '{8'h12, 8'h34, 8'h56, 8'h78});
      end_xfer();
      chk_pix(0, 16'h1234, 16'd0, 16'd0, 1'b0);
      chk_pix(1, 16'h5678, 16'd1, 16'd0, 1'b0);
   endtask

   task automatic test_odd_bytes();
      clear_q();
      send_seq(8'h2C, '{8'hAA, 8'hBB, 8'hCC});
      send_seq(8'h00, '{8'h11, 8'h22});
      end_xfer();
      checks++;
      if (pq_data.size() != 1) begin
         failures++;
         $display("FAIL odd_npix: got %0d want 1", pq_data.size());
      end
      chk_pix(0, 16'hAABB, 16'd0, 16'd0, 1'b0);
   endtask

   task automatic test_sc_gt_ec();
      clear_q();
      send_seq(8'h2A, '{8'h00, 8'h05, 8'h00, 8'h03});
      send_seq(8'h2B, '{8'h00, 8'h00, 8'h00, 8'h01});
      send_seq(8'h2C, '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03});
      end_xfer();
      chk_pix(0, 16'h0001, 16'd5, 16'd0, 1'b0);
      chk_pix(1, 16'h0002, 16'd5, 16'd1, 1'b1);
      chk_pix(2, 16'h0003, 16'd5, 16'd0, 1'b0);
      checks++;
      if (stray_fd != 0) begin
         failures++;
         $display("FAIL stray_frame_done: got %0d want 0", stray_fd);
      end
   endtask

   initial begin
      test_reset();
      test_dispon();
      test_window_frame();
      test_abort();
      test_partial_caset();
      test_odd_bytes();
      test_sc_gt_ec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
